eq_serial_ctrl: RTL

EQ_SERIAL_CTRL -- requirements
Module: eq_serial_ctrl

---
 rtl/eq_pkg.sv | 10 +
 rtl/eq4.sv | 8 +
 rtl/eq_serial_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared types and constants for the serial nibble comparator
package eq_pkg;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/eq4.sv
// rtl/eq4.sv - 4-bit equality comparator
module eq4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       res
);
  assign res = (a == b);
endmodule

// File: rtl/eq_serial_ctrl.sv
// rtl/eq_serial_ctrl.sv - compares two operands one nibble per cycle, LSB first,
// through a single shared eq4, stopping at the first mismatching nibble.
module eq_serial_ctrl
  import eq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [WIDTH-1:0]                   a,
  input  logic [WIDTH-1:0]                   b,
  output logic                               busy,
  output logic                               done,
  output logic                               res,
  output logic [$clog2(WIDTH/4+1)-1:0]       cmp_cnt
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = $clog2(NIBBLES + 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
  logic [CW-1:0]    idx, idx_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             res_q, res_n;
  logic [NIB_W-1:0] nib_a, nib_b;
  logic             nib_eq;

  assign nib_a = a_q[NIB_W*int'(idx) +: NIB_W];
  assign nib_b = b_q[NIB_W*int'(idx) +: NIB_W];

  eq4 u_eq4 (
    .a   (nib_a),
    .b   (nib_b),
    .res (nib_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      cnt_q <= '0;
      res_q <= 1'b0;
    end else begin
      state <= state_n;
      a_q   <= a_n;
      b_q   <= b_n;
      idx   <= idx_n;
      cnt_q <= cnt_n;
      res_q <= res_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    idx_n   = idx;
    cnt_n   = cnt_q;
    res_n   = res_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          a_n     = a;
          b_n     = b;
          idx_n   = '0;
          cnt_n   = '0;
          state_n = CMP;
        end
      end
      CMP: begin
        cnt_n = cnt_q + CW'(1);
        // a mismatch on any nibble settles the result, so leave early
        if (!nib_eq) begin
          res_n   = 1'b0;
          state_n = DONE;
        end else if (idx == CW'(NIBBLES - 1)) begin
          res_n   = 1'b1;
          state_n = DONE;
        end else begin
          idx_n = idx + CW'(1);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign res     = res_q;
  assign cmp_cnt = cnt_q;
endmodule
